// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the CPU front end.
//   INSTR_W          : instruction word width
//   NOP_INSTR        : encoding substituted for fetches outside populated memory
//   PC_INC           : byte distance between sequential instruction words
//   DEFAULT_RESET_PC : byte address fetched first after reset
//   fetch_state_e    : occupancy of the fetch/decode boundary register
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [63:0] PC_INC           = 64'd4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_0000_0000;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage in front of a synchronous-read instruction memory.
// Owns the program counter, drives the memory word index, pairs each returned
// word with its PC and hands it to decode with a valid flag. Supports decode
// stall, zero-bubble redirects and NOP substitution beyond populated memory.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   stall        in   decode cannot accept the presented instruction
//   redirect     in   taken branch/jump; fetch restarts at redirect_pc
//   redirect_pc  in   byte target address (n+1 bits)
//   RD_Address   out  word index to memory (selected PC >> 2)
//   mem_data     in   memory read data, one edge after RD_Address
//   instr        out  instruction presented to decode
//   instr_pc     out  byte PC of instr
//   instr_valid  out  instr/instr_pc meaningful
//   misalign     out  one-cycle pulse: accepted redirect target not word aligned
//   fetch_fault  out  presented instruction came from beyond MEM_WORDS
//   fetch_count  out  instructions accepted by decode (wraps at 2^32)
// -----------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int         n         = 63,
    parameter logic [n:0] RESET_PC  = (n+1)'(DEFAULT_RESET_PC),
    parameter logic [n:0] MEM_WORDS = (n+1)'(64'd1024)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [n:0]         redirect_pc,
    output logic [n:0]         RD_Address,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [n:0]         instr_pc,
    output logic               instr_valid,
    output logic               misalign,
    output logic               fetch_fault,
    output logic [31:0]        fetch_count
);

    localparam logic [n:0] PC_INC_N = (n+1)'(PC_INC);

    // The full word index is compared, so high PC bits can never alias into range.
    function automatic logic idx_fault(input logic [n:0] pc);
        logic [n:0] idx;
        idx = {2'b00, pc[n:2]};
        return (idx >= MEM_WORDS);
    endfunction

    fetch_state_e state_q, state_d;
    logic [n:0]   pc_q, pc_d;          // next PC to fetch
    logic [n:0]   dpc_q, dpc_d;        // PC of the word currently on mem_data
    logic         fault_q, fault_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  cnt_q, cnt_d;

    logic [n:0]   tgt_s;
    logic [n:0]   sel_pc_s;
    logic         sel_fault_s;
    logic         hold_s;

    // Hold only matters when something is actually presented to decode.
    assign hold_s = stall && (state_q == ST_VALID);

    // Address select: redirect, then re-read of held word, then sequential PC.
    always_comb begin
        tgt_s = {redirect_pc[n:2], 2'b00};
        if (redirect) begin
            sel_pc_s = tgt_s;
        end else if (hold_s) begin
            sel_pc_s = dpc_q;
        end else begin
            sel_pc_s = pc_q;
        end
        sel_fault_s = idx_fault(sel_pc_s);
    end

    assign RD_Address = {2'b00, sel_pc_s[n:2]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any non-reset edge leaves the boundary occupied.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: state_d = ST_VALID;
            ST_VALID: state_d = ST_VALID;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Datapath next state with redirect > hold > sequential priority.
    always_comb begin
        pc_d       = pc_q;
        dpc_d      = dpc_q;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
        misalign_d = 1'b0;
        if (redirect) begin
            // Word presented this cycle is wrong-path: not counted.
            dpc_d      = sel_pc_s;
            pc_d       = sel_pc_s + PC_INC_N;
            fault_d    = sel_fault_s;
            misalign_d = (redirect_pc[1:0] != 2'b00);
        end else if (hold_s) begin
            // Everything holds; misalign is a pulse and so is not held.
            misalign_d = 1'b0;
        end else begin
            dpc_d   = pc_q;
            pc_d    = pc_q + PC_INC_N;
            fault_d = sel_fault_s;
            if (state_q == ST_VALID) begin
                cnt_d = cnt_q + 32'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            dpc_q      <= RESET_PC;
            fault_q    <= 1'b0;
            misalign_q <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            dpc_q      <= dpc_d;
            fault_q    <= fault_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    // FSM / datapath outputs to decode.
    always_comb begin
        instr_valid = (state_q == ST_VALID);
        instr       = fault_q ? NOP_INSTR : mem_data;
        instr_pc    = dpc_q;
        fetch_fault = fault_q & (state_q == ST_VALID);
        misalign    = misalign_q;
        fetch_count = cnt_q;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of `insMem`: it owns the program counter and drives the memory's word-index read address. It aligns each synchronously-read instruction word with its PC and presents the pair to decode with a valid flag. It supports decode back-pressure (stall) and zero-bubble control-flow redirects, and substitutes a NOP for fetches outside the populated memory.

## Interface
- `n`, 63: address MSB index; PC and address ports are n+1 bits.
- `RESET_PC`, 0: byte address fetched first after reset.
- `MEM_WORDS`, 1024: number of populated instruction words; word indices ≥ MEM_WORDS are faults.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  **one clock; reset is synchronous and active-low.**
- `stall`  in  1  decode cannot accept the presented instruction.
- `redirect`  in  1  branch/jump taken; fetch restarts at `redirect_pc`.
- `redirect_pc`  in  n+1  byte target address.
- `RD_Address`  out  n+1  word index to `insMem`: selected PC >> 2, zero-extended.
- `mem_data`  in  32  `insMem.data_out`, registered one edge after `RD_Address`.
- `instr`  out  32  instruction to decode.
- `instr_pc`  out  n+1  byte PC of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` meaningful.
- `misalign`  out  1  one-cycle pulse: accepted redirect had `redirect_pc[1:0]` ≠ 0.
- `fetch_fault`  out  1  presented instruction came from a word index ≥ MEM_WORDS.
- `fetch_count`  out  32  instructions accepted by decode.

## Operation
- State registers: `pc_q` (next PC to fetch), `pc_d` (PC of word now on `mem_data`), `v_d` (EMPTY=0 / VALID=1), `fault_d`, `fetch_count`.
- Address select, priority high→low:
  - `redirect` → target with bits [1:0] forced to 0;
  - `stall && v_d` → `pc_d` (re-read the held instruction so `mem_data` stays stable);
  - else → `pc_q`.
- Edge update, priority high→low:
  - `!rst_n` → `pc_q`=`pc_d`=RESET_PC, `v_d`=0, `fault_d`=0, `fetch_count`=0, `misalign`=0.
  - `redirect` → `pc_d`=aligned target, `pc_q`=aligned target+4, `v_d`=1; `fault_d` set from the target's index; `misalign` registered from `redirect_pc[1:0]`≠0. The instruction presented in this cycle is wrong-path and is not counted.
  - `stall && v_d` → hold all registers.
  - else → `pc_d`=`pc_q`, `pc_q`=`pc_q`+4, `v_d`=1, `fault_d` from `pc_q`'s index. If `v_d` was 1, increment `fetch_count`.
- Outputs: `instr` = `fault_d ? 32'h00000013 : mem_data`; `instr_pc`=`pc_d`; `instr_valid`=`v_d`; `fetch_fault`=`fault_d & v_d`.
- Arithmetic: PC+4 wraps modulo 2^(n+1). `fetch_count` wraps modulo 2^32. Fault compare uses the full PC>>2, not a truncated value.
- `stall` with `v_d`=0 is ignored (nothing is held).

## Timing
- Reset values: `RD_Address`=RESET_PC>>2, `instr_valid`=0, `instr_pc`=RESET_PC, `misalign`=0, `fetch_fault`=0, `fetch_count`=0.
- First valid instruction: 1 cycle after `rst_n` rises (EMPTY→VALID on the first non-reset edge).
- Steady state: one instruction per cycle. Latency from address to `instr` is 1 cycle.
- Redirect: zero bubble. The target instruction is valid in the cycle after `redirect`.
- Redirect and stall in the same cycle: redirect wins.
- Reset mid-stall or mid-redirect: reset wins. No in-flight data survives; `instr_valid`=0 in the next cycle.
- Stall release: the held instruction is accepted on the first edge with `stall`=0, and the next sequential PC follows with no gap.

## Structure
- Shared package `cpu_pkg`:
  - `INSTR_W`=32;
  - `NOP_INSTR`=32'h00000013;
  - PC increment constant 4;
  - default `RESET_PC`.
- Flat module; no sub-module is warranted. The address mux, the 3-way update priority, and the counter fit in one file.

## Test plan
- Reset release with word0=0x015A04B3, word1=0x015A34B3 → cycle 1: `instr`=0x015A04B3, `instr_pc`=0, valid. Cycle 2: `instr`=0x015A34B3, `instr_pc`=4. `fetch_count`=1 after cycle 2.
- Stall asserted for 3 cycles while `instr_pc`=8 → `instr_pc`=8 and `instr` stable for all 3 cycles; `RD_Address`=2; `fetch_count` unchanged. After release: `instr_pc`=12.
- `redirect`=1, `redirect_pc`=0x40 while `stall`=1 → next cycle `instr_pc`=0x40, `instr`=word 16, `RD_Address` in the redirect cycle =16. Wrong-path instruction not counted.
- `redirect_pc`=0x42 → `misalign` pulses 1 cycle; `instr_pc`=0x40.
- Redirect to 0xFFC (MEM_WORDS=1024) → `instr_pc`=0xFFC, `fetch_fault`=0. Next: `instr_pc`=0x1000, `instr`=0x00000013, `fetch_fault`=1.
- `rst_n` low for 1 cycle mid-stream during a stall → next cycle `instr_valid`=0, `fetch_count`=0, `RD_Address`=0. Cycle after: `instr_pc`=0, valid.
